clasificador_vc: RTL
====================

Name: clasificador_vc

Overview:
- Ingress side of the transaction-layer VC path; sits upstream of the VC0/VC1 FIFOs that the output arbiter drains.
- Accepts 6-bit words from the link side and buffers them in a 4-entry internal FIFO.
- Classifies each word by its class bit and pushes it into the VC0 or VC1 FIFO, honouring per-VC almost-full back-pressure.
- Generates a pause to the upstream source and tracks per-VC traffic counts and overflow errors.

Parameters:
- BW, 6, word width.
- DEPTH, 4, internal FIFO entries (power of two).
- PAUSE_TH, 3, occupancy at or above which in_pause asserts.
- CNT_W, 8, width of the per-VC word counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_push  in  1  upstream word valid
- in_data  in  BW  upstream word; bit BW-1 is the class bit (0 = VC0, 1 = VC1)
- VC0_almost_full  in  1  VC0 FIFO cannot accept
- VC1_almost_full  in  1  VC1 FIFO cannot accept
- VC0_push  out  1  write strobe to VC0 FIFO
- VC0_data  out  BW  word to VC0 FIFO
- VC1_push  out  1  write strobe to VC1 FIFO
- VC1_data  out  BW  word to VC1 FIFO
- in_pause  out  1  upstream must stop pushing
- state  out  2  00 IDLE, 01 ACTIVE, 10 ERROR
- cnt_vc0  out  CNT_W  words delivered to VC0
- cnt_vc1  out  CNT_W  words delivered to VC1

Behaviour:
- Reset (sampled at the clk edge while reset=1):
  - All outputs are 0; FIFO pointers and occupancy are 0; state = IDLE.
  - Reset overrides all activity, including mid-transfer. Words in flight are discarded and no push is emitted in the cycle after reset.
- Enqueue:
  - in_push=1 with occupancy < DEPTH writes in_data at the edge.
  - in_push=1 with occupancy = DEPTH and no dispatch in the same cycle drops the word and enters ERROR.
  - in_push=1 with occupancy = DEPTH and a dispatch in the same cycle is accepted; occupancy is unchanged.
- Dispatch:
  - Evaluated combinationally each cycle on the FIFO head.
  - Condition: FIFO non-empty, state != ERROR, and the almost_full of the target VC (the head's class bit) is 0.
  - When the condition holds, the head is popped at the edge, and VCx_push=1 / VCx_data=head are registered for the next cycle.
  - At most one word is dispatched per cycle.
  - The non-target VC output has push=0 and data=0. When nothing is dispatched, both push=0 and both data=0.
- Head-of-line blocking: a head word whose target VC is almost full stalls the whole FIFO, even if later words target the other VC. No reordering.
- Latency: a word accepted at edge N into an empty FIFO, with its target not almost full, shows VCx_push=1 in the cycle after edge N+1 (2 cycles).
- Throughput: 1 word per cycle sustained.
- in_pause:
  - Registered: 1 when next occupancy >= PAUSE_TH, else 0.
  - Forced to 1 in ERROR.
- Counters:
  - cnt_vcx increments by 1 at the edge that registers VCx_push=1.
  - Wraps modulo 2^CNT_W without error.
- State machine:
  - IDLE -> ACTIVE when next occupancy > 0.
  - ACTIVE -> IDLE when next occupancy = 0.
  - Any state -> ERROR on a dropped word.
  - ERROR is sticky until reset. In ERROR: no enqueue, no dispatch, FIFO contents frozen, push outputs 0.
- Simultaneous events: a push into an empty FIFO and its dispatch cannot occur in the same cycle (no bypass). Pause and almost_full changes take effect on the cycle they are sampled.

Test Plan:
1. Reset release, then push 6'b110100, 6'b010110 on consecutive cycles, both almost_full=0 -> VC1_push with 110100 two cycles after first push, then VC0_push with 010110 next cycle; cnt_vc1=1, cnt_vc0=1; state returns to IDLE.
2. VC1_almost_full=1, push 6'b100101 then 6'b000011 -> no push output, FIFO holds 2 (HOL blocking). Deassert VC1_almost_full -> 100101 to VC1, then 000011 to VC0 on successive cycles.
3. Both almost_full=1, push 3 words -> in_pause=1 after third accept. Push 4th -> accepted, occupancy 4. Release VC0_almost_full with VC0-class head -> pops resume and in_pause drops when occupancy < 3.
4. Occupancy 4, almost_full=1, push a 5th word -> state=ERROR, in_pause=1, word dropped. Release almost_full -> no dispatch. Assert reset one cycle -> all outputs 0, state IDLE.
5. Stream 256 VC0-class words with no back-pressure -> 256 consecutive VC0_push cycles, cnt_vc0 wraps to 0, state never ERROR.
6. Assert reset while 3 words are queued and a push is registered on VC0 -> next cycle VC0_push=0, counters 0, no queued word ever emitted.

Source files
------------

// File: rtl/clasificador_vc.sv
// clasificador_vc: ingress VC classifier.
// Buffers upstream words in a small FIFO and steers the head word to the VC0 or
// VC1 FIFO according to its class bit (MSB), honouring per-VC almost-full.
// Ports:
//   clk, reset (sync, active-high)
//   in_push/in_data           : upstream word stream (in_data[BW-1] = class)
//   VC0_almost_full/VC1_...   : downstream back-pressure
//   VC0_push/VC0_data, VC1_push/VC1_data : registered writes to the VC FIFOs
//   in_pause                  : registered pause request to upstream
//   state                     : 00 IDLE, 01 ACTIVE, 10 ERROR
//   cnt_vc0/cnt_vc1           : wrapping counts of words delivered per VC
//
// state  | meaning
// IDLE   | internal FIFO empty, no error
// ACTIVE | internal FIFO holds at least one word
// ERROR  | a word was dropped; frozen until reset
module clasificador_vc #(
  parameter int BW       = 6,
  parameter int DEPTH    = 4,
  parameter int PAUSE_TH = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_push,
  input  logic [BW-1:0]    in_data,
  input  logic             VC0_almost_full,
  input  logic             VC1_almost_full,
  output logic             VC0_push,
  output logic [BW-1:0]    VC0_data,
  output logic             VC1_push,
  output logic [BW-1:0]    VC1_data,
  output logic             in_pause,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_vc0,
  output logic [CNT_W-1:0] cnt_vc1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    ERROR  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     occ, occ_d;
  logic [BW-1:0]   head;
  logic            head_vc;
  logic            dispatch;
  logic            enq;
  logic            drop;
  logic            full;
  logic            pause_d;

  assign head    = mem[rd_ptr];
  assign head_vc = head[BW-1];
  assign full    = (occ == (AW+1)'(DEPTH));
  assign state   = state_q;

  always_comb begin
    dispatch = 1'b0;
    enq      = 1'b0;
    drop     = 1'b0;
    occ_d    = occ;
    state_d  = state_q;
    pause_d  = 1'b0;
    if (state_q != ERROR) begin
      // Head-of-line: only the head's own VC back-pressure matters.
      dispatch = (occ != '0) && !(head_vc ? VC1_almost_full : VC0_almost_full);
      // A full FIFO still accepts when the head leaves in the same cycle.
      enq      = in_push && (!full || dispatch);
      drop     = in_push && full && !dispatch;
    end
    case ({enq, dispatch})
      2'b10:   occ_d = occ + 1'b1;
      2'b01:   occ_d = occ - 1'b1;
      default: occ_d = occ;
    endcase
    if (drop || state_q == ERROR)
      state_d = ERROR;
    else if (occ_d != '0)
      state_d = ACTIVE;
    else
      state_d = IDLE;
    pause_d = (state_d == ERROR) || (occ_d >= (AW+1)'(PAUSE_TH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      VC0_push <= 1'b0;
      VC0_data <= '0;
      VC1_push <= 1'b0;
      VC1_data <= '0;
      in_pause <= 1'b0;
      cnt_vc0  <= '0;
      cnt_vc1  <= '0;
    end else begin
      state_q  <= state_d;
      occ      <= occ_d;
      in_pause <= pause_d;
      VC0_push <= dispatch && !head_vc;
      VC0_data <= (dispatch && !head_vc) ? head : '0;
      VC1_push <= dispatch && head_vc;
      VC1_data <= (dispatch && head_vc) ? head : '0;
      if (dispatch) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head_vc) cnt_vc1 <= cnt_vc1 + 1'b1;
        else         cnt_vc0 <= cnt_vc0 + 1'b1;
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && enq) mem[wr_ptr] <= in_data;
  end

endmodule
